// File: rtl/sub_shift_seq.sv
// Byte-serial SubBytes + ShiftRows round stage.
// Streams the captured AES state LANES bytes per cycle through external S-boxes
// and writes each substituted byte straight into its ShiftRows position.
//
// state | meaning
// IDLE  | waiting for a state, in_ready high
// RUN   | issuing one group of LANES bytes per cycle to the S-boxes
// DRAIN | collecting the last group from a registered S-box
// DONE  | out_state complete, out_valid held until out_ready
module sub_shift_seq #(
  parameter int LANES    = 1,
  parameter int SBOX_LAT = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               abort,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [127:0]       in_state,
  output logic [8*LANES-1:0] sbox_in,
  input  logic [8*LANES-1:0] sbox_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [127:0]       out_state,
  output logic               busy
);

  localparam int GROUPS = 16 / LANES;
  localparam int CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [127:0]  cap;
  logic          last;
  logic          wb_en;
  int            wb_grp;

  // byte i sits at [127-8i -: 8], i = row + 4*col
  function automatic logic [7:0] get_byte(input logic [127:0] s, input int i);
    return s[127-8*i -: 8];
  endfunction

  // ShiftRows destination of input byte (r,c): (r, (c-r) mod 4)
  function automatic int dst_idx(input int i);
    int r;
    int c;
    r = i % 4;
    c = i / 4;
    return r + 4 * ((c - r) & 3);
  endfunction

  function automatic logic [8*LANES-1:0] group_bytes(input logic [127:0] s, input int g);
    logic [8*LANES-1:0] v;
    v = '0;
    for (int k = 0; k < LANES; k++) begin
      v[8*k +: 8] = get_byte(s, g * LANES + k);
    end
    return v;
  endfunction

  assign in_ready = (state == IDLE);
  assign busy     = (state == RUN) || (state == DRAIN);
  assign last     = (cnt == CW'(GROUPS - 1));

  // Select which issued group the S-box results belong to this cycle.
  always_comb begin
    wb_en  = 1'b0;
    wb_grp = 0;
    if (SBOX_LAT == 0) begin
      wb_en  = (state == RUN);
      wb_grp = int'(cnt);
    end else if (state == RUN && cnt != '0) begin
      wb_en  = 1'b1;
      wb_grp = int'(cnt) - 1;
    end else if (state == DRAIN) begin
      wb_en  = 1'b1;
      wb_grp = GROUPS - 1;
    end
  end

  // Sequencer, S-box feed and ShiftRows-placed write-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      cap       <= '0;
      out_state <= '0;
      out_valid <= 1'b0;
      sbox_in   <= '0;
    end else if (abort) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      sbox_in   <= '0;
    end else begin
      if (wb_en) begin
        for (int k = 0; k < LANES; k++) begin
          out_state[127-8*dst_idx(wb_grp*LANES+k) -: 8] <= sbox_out[8*k +: 8];
        end
      end
      case (state)
        IDLE: begin
          if (in_valid) begin
            cap     <= in_state;
            cnt     <= '0;
            sbox_in <= group_bytes(in_state, 0);
            state   <= RUN;
          end
        end
        RUN: begin
          if (last) begin
            cnt     <= '0;
            sbox_in <= '0;
            if (SBOX_LAT == 0) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end else begin
            cnt     <= cnt + CW'(1);
            sbox_in <= group_bytes(cap, int'(cnt) + 1);
          end
        end
        DRAIN: begin
          state     <= DONE;
          out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_shift_seq.sv
// Bench for sub_shift_seq: one instance with LANES=1/SBOX_LAT=0 and one with
// LANES=4/SBOX_LAT=1, each fed by a bench S-box built from GF(2^8) arithmetic.
module tb_sub_shift_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         abort0, in_valid0, out_ready0, in_ready0, out_valid0, busy0;
  logic [127:0] in_state0, out_state0;
  logic [7:0]   sbox_in0, sbox_out0;

  logic         abort1, in_valid1, out_ready1, in_ready1, out_valid1, busy1;
  logic [127:0] in_state1, out_state1;
  logic [31:0]  sbox_in1, sbox_out1;

  logic [7:0] sbox_tab [256];
  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [127:0] din;
    logic [127:0] dout;
  } vec_t;
  vec_t vecs [5];

  sub_shift_seq #(.LANES(1), .SBOX_LAT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .abort(abort0), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_state(in_state0), .sbox_in(sbox_in0), .sbox_out(sbox_out0), .out_valid(out_valid0),
    .out_ready(out_ready0), .out_state(out_state0), .busy(busy0)
  );

  sub_shift_seq #(.LANES(4), .SBOX_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .abort(abort1), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_state(in_state1), .sbox_in(sbox_in1), .sbox_out(sbox_out1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_state(out_state1), .busy(busy1)
  );

  // combinational S-box for u0, registered S-box for u1
  always_comb sbox_out0 = sbox_tab[sbox_in0];
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) sbox_out1[8*k +: 8] <= sbox_tab[sbox_in1[8*k +: 8]];
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_tab[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic ov(input int sel);
    return (sel != 0) ? out_valid1 : out_valid0;
  endfunction
  function automatic logic ir(input int sel);
    return (sel != 0) ? in_ready1 : in_ready0;
  endfunction
  function automatic logic bz(input int sel);
    return (sel != 0) ? busy1 : busy0;
  endfunction
  function automatic logic [127:0] ost(input int sel);
    return (sel != 0) ? out_state1 : out_state0;
  endfunction
  function automatic logic [31:0] sb(input int sel);
    return (sel != 0) ? sbox_in1 : {24'h0, sbox_in0};
  endfunction

  task automatic drive_in(input int sel, input logic v, input logic [127:0] st);
    if (sel != 0) begin in_valid1 = v; in_state1 = st; end
    else begin in_valid0 = v; in_state0 = st; end
  endtask

  task automatic set_ready(input int sel, input logic v);
    if (sel != 0) out_ready1 = v;
    else out_ready0 = v;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Accept one state, measure latency, optionally stall, then hand it off.
  task automatic run_vec(input int sel, input logic [127:0] st, input logic [127:0] exp,
                         input int stall, input string name, output logic [31:0] first_sb);
    int n;
    @(negedge clk);
    chk($sformatf("%s ready", name), 128'(ir(sel)), 128'd1);
    drive_in(sel, 1'b1, st);
    @(posedge clk);
    n = 1;
    @(negedge clk);
    drive_in(sel, 1'b0, '0);
    first_sb = sb(sel);
    chk($sformatf("%s busy", name), 128'(bz(sel)), 128'd1);
    while (!ov(sel) && n < 100) begin
      step();
      n++;
    end
    chk($sformatf("%s latency", name), 128'(n), (sel != 0) ? 128'd6 : 128'd17);
    chk($sformatf("%s out_state", name), ost(sel), exp);
    chk($sformatf("%s sbox_in idle", name), 128'(sb(sel)), 128'd0);
    for (int i = 0; i < stall; i++) begin
      step();
      chk($sformatf("%s stall valid", name), 128'(ov(sel)), 128'd1);
      chk($sformatf("%s stall data", name), ost(sel), exp);
      chk($sformatf("%s stall ready", name), 128'(ir(sel)), 128'd0);
    end
    set_ready(sel, 1'b1);
    step();
    set_ready(sel, 1'b0);
    chk($sformatf("%s valid drop", name), 128'(ov(sel)), 128'd0);
    chk($sformatf("%s ready back", name), 128'(ir(sel)), 128'd1);
  endtask

  initial begin
    logic [31:0] fsb;
    logic        seen;
    int          n;

    vecs[0] = '{128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd4bf5d30e0b452aeb84111f11e2798e5};
    vecs[1] = '{128'h00000000000000000000000000000000, 128'h63636363636363636363636363636363};
    vecs[2] = '{128'ha49c7ff2689f352b6b5bea43026a5049, 128'h49db873b453953897f02d2f177de961a};
    vecs[3] = '{128'haa8f5f0361dde3ef82d24ad26832469a, 128'hacc1d6b8efb55a7b1323cfdf457311b5};
    vecs[4] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h636b6776f201ab7b30d777c5fe7c6f2b};

    abort0 = 0; in_valid0 = 0; out_ready0 = 0; in_state0 = '0;
    abort1 = 0; in_valid1 = 0; out_ready1 = 0; in_state1 = '0;
    build_sbox();

    repeat (3) @(negedge clk);
    chk("rst out_valid0", 128'(out_valid0), 128'd0);
    chk("rst in_ready0", 128'(in_ready0), 128'd1);
    chk("rst busy1", 128'(busy1), 128'd0);
    chk("rst sbox_in1", 128'(sbox_in1), 128'd0);
    chk("rst out_state1", out_state1, 128'd0);
    rst_n = 1'b1;

    for (int sel = 0; sel < 2; sel++) begin
      for (int i = 0; i < 5; i++) begin
        run_vec(sel, vecs[i].din, vecs[i].dout, 0, $sformatf("vec%0d/u%0d", i, sel), fsb);
        if (i == 0) chk($sformatf("first sbox_in u%0d", sel), 128'(fsb),
                        (sel != 0) ? 128'hbee33d19 : 128'h19);
      end
    end

    run_vec(0, vecs[1].din, vecs[1].dout, 10, "stall", fsb);

    // back-to-back with out_ready held high
    @(negedge clk);
    in_valid0 = 1; in_state0 = vecs[2].din; out_ready0 = 1;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    in_state0 = vecs[3].din;
    while (!out_valid0 && n < 100) begin step(); n++; end
    chk("b2b A latency", 128'(n), 128'd17);
    chk("b2b A data", out_state0, vecs[2].dout);
    chk("b2b no accept in handshake", 128'(in_ready0), 128'd0);
    step();
    chk("b2b idle valid", 128'(out_valid0), 128'd0);
    chk("b2b idle ready", 128'(in_ready0), 128'd1);
    step();
    chk("b2b B accepted", 128'(busy0), 128'd1);
    in_valid0 = 0;
    n = 1;
    while (!out_valid0 && n < 100) begin step(); n++; end
    chk("b2b B latency", 128'(n), 128'd17);
    chk("b2b B data", out_state0, vecs[3].dout);
    step();
    out_ready0 = 0;
    chk("b2b B done", 128'(out_valid0), 128'd0);

    // abort at cnt=7
    @(negedge clk);
    in_valid0 = 1; in_state0 = vecs[0].din;
    step();
    in_valid0 = 0;
    repeat (7) step();
    chk("abort cnt7 sbox_in", 128'(sbox_in0), 128'h2b);
    abort0 = 1;
    step();
    abort0 = 0;
    chk("abort ready", 128'(in_ready0), 128'd1);
    chk("abort busy", 128'(busy0), 128'd0);
    chk("abort sbox_in", 128'(sbox_in0), 128'd0);
    seen = 0;
    repeat (25) begin step(); if (out_valid0) seen = 1; end
    chk("abort no out_valid", 128'(seen), 128'd0);
    abort0 = 1; in_valid0 = 1;
    step();
    abort0 = 0; in_valid0 = 0;
    chk("abort idle no capture", 128'(busy0), 128'd0);
    run_vec(0, vecs[4].din, vecs[4].dout, 0, "post-abort", fsb);

    // reset at cnt=5
    @(negedge clk);
    in_valid0 = 1; in_state0 = vecs[2].din;
    step();
    in_valid0 = 0;
    repeat (5) step();
    chk("rst cnt5 sbox_in", 128'(sbox_in0), 128'h9f);
    rst_n = 1'b0;
    #1;
    chk("midrst out_state", out_state0, 128'd0);
    chk("midrst out_valid", 128'(out_valid0), 128'd0);
    chk("midrst busy", 128'(busy0), 128'd0);
    chk("midrst in_ready", 128'(in_ready0), 128'd1);
    chk("midrst sbox_in", 128'(sbox_in0), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (25) begin step(); if (out_valid0) seen = 1; end
    chk("midrst no out_valid", 128'(seen), 128'd0);
    run_vec(0, vecs[0].din, vecs[0].dout, 0, "post-reset", fsb);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
